// File: rtl/peak_detector.sv
// Pulse peak detector on a filtered sample stream: finds pulses that rise above a
// programmable threshold and reports each pulse's maximum, its timestamp and pile-up/width flags.
module peak_detector #(
  parameter int unsigned SIZE_FILTER_DATA = 16,
  parameter int unsigned SIZE_TIME        = 32,
  parameter int unsigned SIZE_DEAD        = 8,
  parameter int unsigned MAX_WIDTH        = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] input_data,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  input  logic [SIZE_DEAD-1:0]        dead_time,
  output logic                        peak_valid,
  output logic [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic [SIZE_TIME-1:0]        peak_time,
  output logic [1:0]                  peak_flags,
  output logic                        busy,
  output logic [15:0]                 event_count
);

  localparam int unsigned WCNT_W = $clog2(MAX_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_e;

  state_e                      state_q, state_d;
  logic [SIZE_TIME-1:0]        ts_q, ts_d;
  logic [SIZE_FILTER_DATA-1:0] data_q, data_d;
  logic [SIZE_TIME-1:0]        t_q, t_d;
  logic                        vld_q, vld_d;
  logic                        above_prev_q, above_prev_d;
  logic [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic [SIZE_TIME-1:0]        tmax_q, tmax_d;
  logic [WCNT_W-1:0]           wcnt_q, wcnt_d;
  logic [SIZE_DEAD-1:0]        dcnt_q, dcnt_d;
  logic                        pend_q, pend_d;
  logic                        peak_valid_q, peak_valid_d;
  logic [SIZE_FILTER_DATA-1:0] amp_q, amp_d;
  logic [SIZE_TIME-1:0]        time_q, time_d;
  logic [1:0]                  flags_q, flags_d;
  logic                        busy_q, busy_d;
  logic [15:0]                 count_q, count_d;

  logic above_c;
  logic rise_c;

  // The first pipelined sample after reset is a reset artefact, not data.
  assign above_c = vld_q && ($signed(data_q) > $signed(threshold));
  assign rise_c  = above_c && !above_prev_q;

  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q + SIZE_TIME'(1);
    data_d       = input_data;
    t_d          = ts_q;
    vld_d        = 1'b1;
    above_prev_d = vld_q ? above_c : 1'b1;
    max_d        = max_q;
    tmax_d       = tmax_q;
    wcnt_d       = wcnt_q;
    dcnt_d       = dcnt_q;
    pend_d       = pend_q;
    peak_valid_d = 1'b0;
    amp_d        = amp_q;
    time_d       = time_q;
    flags_d      = flags_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d = ARMED;
          max_d   = data_q;
          tmax_d  = t_q;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ARMED: begin
        // Still above on the exit path can only mean the width limit was hit.
        if (!above_c || (wcnt_q == WCNT_W'(MAX_WIDTH))) begin
          peak_valid_d = 1'b1;
          amp_d        = max_q;
          time_d       = tmax_q;
          flags_d      = {above_c, pend_q};
          count_d      = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          pend_d       = 1'b0;
          dcnt_d       = dead_time;
          state_d      = (dead_time == '0) ? IDLE : DEAD;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          if ($signed(data_q) > $signed(max_q)) begin
            max_d  = data_q;
            tmax_d = t_q;
          end
        end
      end
      DEAD: begin
        if (rise_c) pend_d = 1'b1;
        dcnt_d = dcnt_q - SIZE_DEAD'(1);
        if (dcnt_q == SIZE_DEAD'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ts_q         <= '0;
      data_q       <= '0;
      t_q          <= '0;
      vld_q        <= 1'b0;
      above_prev_q <= 1'b1;
      max_q        <= '0;
      tmax_q       <= '0;
      wcnt_q       <= '0;
      dcnt_q       <= '0;
      pend_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      amp_q        <= '0;
      time_q       <= '0;
      flags_q      <= '0;
      busy_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      data_q       <= data_d;
      t_q          <= t_d;
      vld_q        <= vld_d;
      above_prev_q <= above_prev_d;
      max_q        <= max_d;
      tmax_q       <= tmax_d;
      wcnt_q       <= wcnt_d;
      dcnt_q       <= dcnt_d;
      pend_q       <= pend_d;
      peak_valid_q <= peak_valid_d;
      amp_q        <= amp_d;
      time_q       <= time_d;
      flags_q      <= flags_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
    end
  end

  assign peak_valid     = peak_valid_q;
  assign peak_amplitude = amp_q;
  assign peak_time      = time_q;
  assign peak_flags     = flags_q;
  assign busy           = busy_q;
  assign event_count    = count_q;

endmodule

// File: tb/tb_peak_detector.sv
// Bench for peak_detector: per-cycle vector table plus hand sequences for pile-up,
// width overflow, reset mid-pulse and negative threshold; records checked via a scoreboard.
module tb_peak_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_data;
  logic [15:0] threshold;
  logic [7:0]  dead_time;
  logic        peak_valid;
  logic [15:0] peak_amplitude;
  logic [31:0] peak_time;
  logic [1:0]  peak_flags;
  logic        busy;
  logic [15:0] event_count;

  peak_detector #(
    .SIZE_FILTER_DATA(16), .SIZE_TIME(32), .SIZE_DEAD(8), .MAX_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .dead_time(dead_time), .peak_valid(peak_valid), .peak_amplitude(peak_amplitude),
    .peak_time(peak_time), .peak_flags(peak_flags), .busy(busy), .event_count(event_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] amp;
    logic [31:0] tm;
    logic [1:0]  flags;
  } exp_rec_t;

  typedef struct {
    logic [15:0] din;
    logic        exp_valid;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  exp_rec_t sb[$];
  exp_rec_t mon_e;
  vec_t     tbl[30];
  int       checks = 0;
  int       errors = 0;
  int       tb_ts  = 0;

  // Independent model of the free-running timestamp.
  always @(posedge clk) begin
    if (reset) tb_ts <= 0;
    else       tb_ts <= tb_ts + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at ts=%0d: got %0h expected %0h", name, tb_ts, act, exp);
    end
  endtask

  task automatic push(input int cyc, input logic [15:0] amp, input logic [31:0] tm,
                      input logic [1:0] flags);
    exp_rec_t r;
    r.cyc = cyc; r.amp = amp; r.tm = tm; r.flags = flags;
    sb.push_back(r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drive d from the current cycle until the cycle whose ts equals upto.
  task automatic hold(input logic [15:0] d, input int upto);
    input_data = d;
    while (tb_ts < upto) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (peak_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(peak_valid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("valid_cycle", 64'(tb_ts), 64'(mon_e.cyc));
        chk("record_amp_time_flags", 64'({peak_amplitude, peak_time, peak_flags}),
            64'({mon_e.amp, mon_e.tm, mon_e.flags}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    input_data = '0;
    threshold  = 16'd100;
    dead_time  = 8'd4;
    reset      = 1'b1;

    // Single pulse followed by an equal-peak pulse.
    for (int i = 0; i < 30; i++) begin
      tbl[i].din       = 16'd0;
      tbl[i].exp_busy  = (i >= 14 && i <= 20) || (i >= 23 && i <= 28);
      tbl[i].exp_valid = (i == 17) || (i == 25);
      tbl[i].exp_cnt   = (i >= 25) ? 16'd2 : ((i >= 17) ? 16'd1 : 16'd0);
    end
    tbl[11].din = 16'd50;  tbl[12].din = 16'd150; tbl[13].din = 16'd300;
    tbl[14].din = 16'd250; tbl[15].din = 16'd90;
    tbl[21].din = 16'd200; tbl[22].din = 16'd200;

    do_reset();
    push(17, 16'd300, 32'd13, 2'b00);
    push(25, 16'd200, 32'd21, 2'b00);
    for (int i = 0; i < 30; i++) begin
      input_data = tbl[i].din;
      @(negedge clk);
      if (i == 0) begin
        chk("reset_record", 64'({peak_amplitude, peak_time, peak_flags}), 64'(0));
      end
      chk("busy", 64'(busy), 64'(tbl[i].exp_busy));
      chk("valid", 64'(peak_valid), 64'(tbl[i].exp_valid));
      chk("event_count", 64'(event_count), 64'(tbl[i].exp_cnt));
      @(posedge clk); #1;
    end

    // Pile-up: a pulse inside the dead time flags the next reported pulse.
    dead_time = 8'd10;
    do_reset();
    push(17, 16'd300, 32'd13, 2'b00);
    push(43, 16'd120, 32'd40, 2'b01);
    hold(16'd0, 11);  hold(16'd50, 12);  hold(16'd150, 13); hold(16'd300, 14);
    hold(16'd250, 15); hold(16'd90, 16); hold(16'd0, 19);   hold(16'd300, 20);
    hold(16'd0, 40);  hold(16'd120, 41); hold(16'd0, 46);
    @(negedge clk);
    chk("pileup_count", 64'(event_count), 64'(2));
    @(posedge clk); #1;

    // Width overflow on a constant high level, then a fresh crossing.
    dead_time = 8'd4;
    do_reset();
    push(15, 16'd500, 32'd5, 2'b10);
    push(37, 16'd500, 32'd34, 2'b00);
    hold(16'd0, 5); hold(16'd500, 25);
    @(negedge clk);
    chk("idle_while_high", 64'(busy), 64'(0));
    hold(16'd500, 31); hold(16'd0, 34); hold(16'd500, 35); hold(16'd0, 40);
    @(negedge clk);
    chk("ovf_count", 64'(event_count), 64'(2));

    // Reset while ARMED discards the pulse; level already high after reset is ignored.
    hold(16'd200, 45);
    @(negedge clk);
    chk("armed_before_reset", 64'(busy), 64'(1));
    do_reset();
    @(negedge clk);
    chk("reset_busy_valid", 64'({busy, peak_valid}), 64'(0));
    chk("reset_outputs", 64'({peak_amplitude, peak_time, peak_flags}), 64'(0));
    chk("reset_count", 64'(event_count), 64'(0));
    push(9, 16'd150, 32'd6, 2'b00);
    hold(16'd200, 4); hold(16'd0, 6); hold(16'd150, 7); hold(16'd0, 12);
    @(negedge clk);
    chk("post_reset_count", 64'(event_count), 64'(1));
    @(posedge clk); #1;

    // Negative threshold, zero dead time, back-to-back pulses.
    threshold  = -16'sd50;
    dead_time  = 8'd0;
    input_data = -16'sd100;
    do_reset();
    push(8, -16'sd10, 32'd5, 2'b00);
    push(10, -16'sd20, 32'd7, 2'b00);
    hold(-16'sd100, 5); hold(-16'sd10, 6); hold(-16'sd60, 7);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] d4[4];
      d4[0] = -16'sd20; d4[1] = -16'sd60; d4[2] = -16'sd100; d4[3] = -16'sd100;
      input_data = d4[i];
      @(negedge clk);
      chk("neg_busy", 64'(busy), 64'(((i % 2) == 0) ? 1 : 0));
      @(posedge clk); #1;
    end
    hold(-16'sd100, 14);
    @(negedge clk);
    chk("neg_count", 64'(event_count), 64'(2));
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_detector.md
Name: peak_detector

Overview:
- Downstream consumer of one vN_filter output (output_data_vN, SIZE_FILTER_DATA wide).
- Detects pulses that rise above a programmable threshold and tracks the maximum of each pulse.
- Reports each pulse as one record: amplitude, timestamp, flags, and a one-cycle valid strobe.
- Applies a programmable dead time after each pulse and flags pile-up.

Parameters:
SIZE_FILTER_DATA, 16, width of the filtered input sample (two's complement, signed)
SIZE_TIME, 32, width of the free-running timestamp counter
SIZE_DEAD, 8, width of the dead_time input
MAX_WIDTH, 255, maximum ARMED duration in cycles before a forced report (>=1)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
input_data  input  SIZE_FILTER_DATA  filtered sample, signed, one per clk
threshold  input  SIZE_FILTER_DATA  signed trigger level, sampled live every cycle
dead_time  input  SIZE_DEAD  dead-time length in cycles, latched on DEAD entry
peak_valid  output  1  one-cycle strobe; record outputs valid while high
peak_amplitude  output  SIZE_FILTER_DATA  signed maximum of the pulse
peak_time  output  SIZE_TIME  timestamp of the maximum sample
peak_flags  output  2  [0] pile_up, [1] width_overflow
busy  output  1  high in ARMED or DEAD
event_count  output  16  number of reported peaks, saturates at 16'hFFFF

Behaviour:
- Reset:
  - Synchronous and active-high; clk is the only clock. Reset overrides all other activity.
  - Clears every output to 0 and sets state to IDLE. ts, the internal counters and the pending flag are also 0.
  - A reset during ARMED or DEAD discards the pulse in progress with no report.
- Timestamp:
  - ts increments every cycle after reset and wraps from 2^SIZE_TIME-1 to 0.
  - A sample present on input_data in the cycle where ts==t carries timestamp t.
  - Internal registering delays data by one cycle; the pipeline must compensate so reported timestamps follow this definition.
- Pipeline:
  - data_r and the aligned sample timestamp t_r are registered every cycle.
  - The FSM acts on data_r.
- Comparisons: signed and strict throughout.
  - above = data_r > threshold.
  - A new maximum requires data_r > max_r. On a tie the earliest sample is kept.
- IDLE:
  - If above: go to ARMED, max_r<=data_r, tmax_r<=t_r, wcnt<=1.
- ARMED:
  - If above and data_r > max_r: update max_r and tmax_r.
  - wcnt increments each cycle.
  - If !above: report and go to DEAD.
  - Else if wcnt==MAX_WIDTH: report with width_overflow=1 and go to DEAD.
  - If the report condition is met, do not update the maximum in that same cycle.
- Report: on the edge that leaves ARMED, register the record; peak_valid is high for exactly the next cycle.
  - peak_amplitude = max_r.
  - peak_time = tmax_r.
  - peak_flags[0] = pending pile_up.
  - peak_flags[1] = overflow condition.
  - event_count increments with saturation.
  - pending pile_up is cleared.
  - End-to-end latency: peak_valid rises 2 cycles after the first below-threshold sample appears on input_data.
- Record hold: peak_amplitude, peak_time and peak_flags hold their values until the next report.
- DEAD entry:
  - Latch dcnt<=dead_time.
  - If dead_time==0, go straight to IDLE instead of DEAD.
- DEAD:
  - dcnt decrements each cycle; at dcnt==1, go to IDLE.
  - A rising crossing during DEAD (above now, not above in the previous cycle) sets pending pile_up; the pulse itself is not reported.
  - After a width_overflow exit, the signal may still be above threshold. That is not a crossing.
- IDLE after DEAD:
  - IDLE waits for a rising crossing, not just a high level. A signal that is still above threshold does not re-arm.
  - The same rule applies after reset: a signal already above threshold at reset does not trigger.
- busy = (state != IDLE).

Test Plan:
1. Single pulse.
   - Stimulus: threshold=100, dead_time=4, input_data 0,50,150,300,250,90,0 at ts=10..16.
   - Response: peak_valid high only in cycle ts=17; amplitude=300, time=13, flags=00, event_count=1.
2. Equal peaks.
   - Stimulus: 0,200,200,0 at ts=20..23, threshold=100.
   - Response: amplitude=200, time=21.
3. Pile-up.
   - Stimulus: dead_time=10; first pulse as in test 1; second pulse 300 at ts=19 (inside DEAD); third pulse 120 at ts=40.
   - Response: no report for ts=19; the ts=40 report has amplitude=120 and flags[0]=1.
4. Width overflow.
   - Stimulus: MAX_WIDTH=8, constant 500 above threshold=100 from ts=5.
   - Response: one report with flags[1]=1 and amplitude=500; no further report until input drops below threshold and rises again.
5. Reset mid-pulse.
   - Stimulus: reset asserted one cycle during ARMED.
   - Response: all outputs 0 next cycle; no peak_valid; ts restarts at 0.
6. Negative threshold and zero dead time.
   - Stimulus: threshold=-50, dead_time=0, back-to-back pulses -10,-60,-20,-60.
   - Response: two reports with amplitudes -10 and -20; busy low in the cycle after each exit.
